// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator in front of a
// word-wide data memory. Sub-word loads are extended here and sub-word
// stores are done as read-modify-write of the containing word.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  // request channel from the execute stage
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // response channel back to the pipeline
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  // data memory port
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  // Highest byte address at which a full word still fits in memory.
  localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW,
    ST_STORE,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  // Only the low halfword of store data is needed after accept: full-word
  // stores load writeData directly at the accept edge.
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        funct3_bad;
  logic        addr_bad;

  // Extend the raw memory word according to the load width code.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] word);
    logic [31:0] result;
    case (f3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_BU:   result = {24'd0, word[7:0]};
      F3_HU:   result = {16'd0, word[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  // Overlay the low byte or halfword of store data onto the old word.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [31:0] old_word,
                                              input logic [15:0] wd);
    logic [31:0] result;
    if (f3 == F3_B) begin
      result = {old_word[31:8], wd[7:0]};
    end else begin
      result = {old_word[31:16], wd[15:0]};
    end
    return result;
  endfunction

  // Request legality: width code valid for the direction, word fits in memory.
  always_comb begin
    funct3_bad = 1'b0;
    if (req_store) begin
      funct3_bad = (req_funct3 > F3_W);
    end else begin
      funct3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                   (req_funct3 == 3'd7);
    end
    addr_bad = (req_addr > LAST_WORD_ADDR);
  end

  // Next-state, datapath updates and handshake/memory strobes.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d = req_funct3;
          wdata_d  = req_wdata[15:0];
          if (funct3_bad || addr_bad) begin
            // Rejected requests never touch the memory port registers.
            resp_err_d  = 1'b1;
            resp_data_d = 32'd0;
            state_d     = ST_RESP;
          end else begin
            address_d = req_addr;
            if (!req_store) begin
              state_d = ST_LOAD;
            end else if (req_funct3 == F3_W) begin
              write_data_d = req_wdata;
              state_d      = ST_STORE;
            end else begin
              state_d = ST_RMW;
            end
          end
        end
      end

      ST_LOAD: begin
        MemRead     = 1'b1;
        resp_data_d = load_extend(funct3_q, readData);
        resp_err_d  = 1'b0;
        state_d     = ST_RESP;
      end

      ST_RMW: begin
        MemRead      = 1'b1;
        write_data_d = store_merge(funct3_q, readData, wdata_q);
        state_d      = ST_STORE;
      end

      ST_STORE: begin
        MemWrite    = 1'b1;
        resp_data_d = 32'd0;
        resp_err_d  = 1'b0;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      funct3_q     <= 3'd0;
      wdata_q      <= 16'd0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign address   = address_q;
  assign writeData = write_data_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule
